// File: rtl/controller_router_if.sv
// Config/step handshake bundle for controller_router.
// master drives requests, slave (the router) answers.
interface controller_router_if #(
    parameter int SEL_W = 2
) ();
    logic             cfg_valid_in;
    logic             cfg_console_in;
    logic [SEL_W-1:0] cfg_p0_in;
    logic [SEL_W-1:0] cfg_p1_in;
    logic             step_in;
    logic             cfg_ready_out;
    logic             cfg_err_out;

    modport master (
        output cfg_valid_in,
        output cfg_console_in,
        output cfg_p0_in,
        output cfg_p1_in,
        output step_in,
        input  cfg_ready_out,
        input  cfg_err_out
    );

    modport slave (
        input  cfg_valid_in,
        input  cfg_console_in,
        input  cfg_p0_in,
        input  cfg_p1_in,
        input  step_in,
        output cfg_ready_out,
        output cfg_err_out
    );
endinterface

// File: rtl/controller_router.sv
// Registered router from N_SRC active-low controllers to NES/SNES ports.
// Every mapping change (or reset) blanks all ports to released for a while.
module controller_router #(
    parameter int BTN_W        = 12,
    parameter int N_SRC        = 3,
    parameter int BLANK_CYCLES = 16,
    parameter int SEL_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [N_SRC*BTN_W-1:0] src_in,
    controller_router_if.slave     cfg_if,
    output logic                   cur_console_out,
    output logic [SEL_W-1:0]       cur_p0_out,
    output logic [SEL_W-1:0]       cur_p1_out,
    output logic [BTN_W-1:0]       NES0,
    output logic [BTN_W-1:0]       NES1,
    output logic [BTN_W-1:0]       SNES0,
    output logic [BTN_W-1:0]       SNES1
);

    localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
    // Two spare bits so p+2 and N_SRC compare without wrapping.
    localparam int IDX_W = SEL_W + 2;
    localparam logic [BTN_W-1:0] OFF = '1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N_SRC);

    typedef enum logic {
        ST_BLANK,
        ST_ACTIVE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_console;
    logic             w_console_nxt;
    logic [SEL_W-1:0] r_p0;
    logic [SEL_W-1:0] w_p0_nxt;
    logic [SEL_W-1:0] r_p1;
    logic [SEL_W-1:0] w_p1_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic [BTN_W-1:0] r_nes0;
    logic [BTN_W-1:0] r_nes1;
    logic [BTN_W-1:0] r_snes0;
    logic [BTN_W-1:0] r_snes1;
    logic [BTN_W-1:0] w_nes0_nxt;
    logic [BTN_W-1:0] w_nes1_nxt;
    logic [BTN_W-1:0] w_snes0_nxt;
    logic [BTN_W-1:0] w_snes1_nxt;

    logic [IDX_W-1:0] w_req_p0;
    logic [IDX_W-1:0] w_req_p1;
    logic             w_legal;
    logic             w_same;

    logic             w_s_console;
    logic [IDX_W-1:0] w_s_p0;
    logic [IDX_W-1:0] w_s_p1;

    logic [BTN_W-1:0] w_sel0;
    logic [BTN_W-1:0] w_sel1;
    logic             w_live;

    // Explicit source lookup; unreachable indices yield OFF.
    function automatic logic [BTN_W-1:0] f_pick(
        input logic [N_SRC*BTN_W-1:0] src,
        input logic [SEL_W-1:0]       idx
    );
        logic [BTN_W-1:0] res;
        res = OFF;
        for (int k = 0; k < N_SRC; k++) begin
            if (IDX_W'(idx) == IDX_W'(k)) begin
                res = src[k*BTN_W +: BTN_W];
            end
        end
        return res;
    endfunction

    // Legality and sameness of the requested config.
    always_comb begin
        w_req_p0 = IDX_W'(cfg_if.cfg_p0_in);
        w_req_p1 = IDX_W'(cfg_if.cfg_p1_in);
        w_legal  = (w_req_p0 < N_IDX) &&
                   (w_req_p1 < N_IDX) &&
                   (w_req_p0 != w_req_p1);
        w_same   = (cfg_if.cfg_console_in == r_console) &&
                   (cfg_if.cfg_p0_in == r_p0) &&
                   (cfg_if.cfg_p1_in == r_p1);
    end

    // Next mapping in (console, p0, p1) order, skipping p0 == p1.
    always_comb begin
        w_s_console = r_console;
        w_s_p0      = IDX_W'(r_p0);
        w_s_p1      = IDX_W'(r_p1) + IDX_W'(1);
        if (w_s_p1 == w_s_p0) begin
            w_s_p1 = w_s_p1 + IDX_W'(1);
        end
        if (w_s_p1 >= N_IDX) begin
            w_s_p0 = w_s_p0 + IDX_W'(1);
            w_s_p1 = '0;
            if (w_s_p0 >= N_IDX) begin
                w_s_p0      = '0;
                w_s_p1      = IDX_W'(1);
                w_s_console = ~r_console;
            end
        end
    end

    // FSM next state, config commit and error pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_console_nxt = r_console;
        w_p0_nxt      = r_p0;
        w_p1_nxt      = r_p1;
        w_err_nxt     = 1'b0;
        unique case (r_state)
            ST_BLANK: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (cfg_if.cfg_valid_in) begin
                    if (!w_legal) begin
                        w_err_nxt = 1'b1;
                    end else if (!w_same) begin
                        w_console_nxt = cfg_if.cfg_console_in;
                        w_p0_nxt      = cfg_if.cfg_p0_in;
                        w_p1_nxt      = cfg_if.cfg_p1_in;
                        w_state_nxt   = ST_BLANK;
                        w_cnt_nxt     = CNT_LOAD;
                    end
                end else if (cfg_if.step_in) begin
                    w_console_nxt = w_s_console;
                    w_p0_nxt      = SEL_W'(w_s_p0);
                    w_p1_nxt      = SEL_W'(w_s_p1);
                    w_state_nxt   = ST_BLANK;
                    w_cnt_nxt     = CNT_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = CNT_LOAD;
            end
        endcase
    end

    // Port words: live only when the next state is ACTIVE.
    always_comb begin
        w_live      = (w_state_nxt == ST_ACTIVE);
        w_sel0      = f_pick(src_in, r_p0);
        w_sel1      = f_pick(src_in, r_p1);
        w_nes0_nxt  = OFF;
        w_nes1_nxt  = OFF;
        w_snes0_nxt = OFF;
        w_snes1_nxt = OFF;
        if (w_live && !r_console) begin
            w_nes0_nxt = w_sel0;
            w_nes1_nxt = w_sel1;
        end
        if (w_live && r_console) begin
            w_snes0_nxt = w_sel0;
            w_snes1_nxt = w_sel1;
        end
    end

    // State, config and port registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_state   <= ST_BLANK;
            r_cnt     <= CNT_LOAD;
            r_console <= 1'b0;
            r_p0      <= '0;
            r_p1      <= SEL_W'(1);
            r_err     <= 1'b0;
            r_nes0    <= OFF;
            r_nes1    <= OFF;
            r_snes0   <= OFF;
            r_snes1   <= OFF;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_console <= w_console_nxt;
            r_p0      <= w_p0_nxt;
            r_p1      <= w_p1_nxt;
            r_err     <= w_err_nxt;
            r_nes0    <= w_nes0_nxt;
            r_nes1    <= w_nes1_nxt;
            r_snes0   <= w_snes0_nxt;
            r_snes1   <= w_snes1_nxt;
        end
    end

    assign cfg_if.cfg_ready_out = (r_state == ST_ACTIVE);
    assign cfg_if.cfg_err_out   = r_err;
    assign cur_console_out      = r_console;
    assign cur_p0_out           = r_p0;
    assign cur_p1_out           = r_p1;
    assign NES0                 = r_nes0;
    assign NES1                 = r_nes1;
    assign SNES0                = r_snes0;
    assign SNES1                = r_snes1;

endmodule

// File: tb/tb_controller_router.sv
// Directed bench for controller_router with BLANK_CYCLES = 4.
// Inputs change and outputs are sampled on the falling edge.
module tb_controller_router;

    localparam int BTN_W = 12;
    localparam int N_SRC = 3;
    localparam int BLANK = 4;
    localparam int SEL_W = 2;
    localparam logic [11:0] OFF = 12'hFFF;
    localparam logic [11:0] S0  = 12'hFFE;
    localparam logic [11:0] S1  = 12'hFFD;
    localparam logic [11:0] S2  = 12'h7FF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [11:0]      src0, src1, src2;
    logic             cur_con;
    logic [SEL_W-1:0] cur_p0, cur_p1;
    logic [11:0]      nes0, nes1, snes0, snes1;

    int n_chk = 0;
    int n_err = 0;

    controller_router_if #(.SEL_W(SEL_W)) cfg_if ();

    controller_router #(
        .BTN_W(BTN_W),
        .N_SRC(N_SRC),
        .BLANK_CYCLES(BLANK),
        .SEL_W(SEL_W)
    ) dut (
        .clk_in(clk),
        .reset_in(rst_n),
        .src_in({src2, src1, src0}),
        .cfg_if(cfg_if),
        .cur_console_out(cur_con),
        .cur_p0_out(cur_p0),
        .cur_p1_out(cur_p1),
        .NES0(nes0),
        .NES1(nes1),
        .SNES0(snes0),
        .SNES1(snes1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic check_ports(input string tag,
                               input logic [11:0] n0, input logic [11:0] n1,
                               input logic [11:0] s0, input logic [11:0] s1);
        chk({tag, ".nes0"}, 32'(nes0), 32'(n0));
        chk({tag, ".nes1"}, 32'(nes1), 32'(n1));
        chk({tag, ".snes0"}, 32'(snes0), 32'(s0));
        chk({tag, ".snes1"}, 32'(snes1), 32'(s1));
    endtask

    task automatic check_cur(input string tag, input logic c,
                             input logic [1:0] p0, input logic [1:0] p1);
        chk({tag, ".con"}, 32'(cur_con), 32'(c));
        chk({tag, ".p0"}, 32'(cur_p0), 32'(p0));
        chk({tag, ".p1"}, 32'(cur_p1), 32'(p1));
    endtask

    task automatic check_active(input string tag,
                                input logic [11:0] n0, input logic [11:0] n1,
                                input logic [11:0] s0, input logic [11:0] s1);
        check_ports(tag, n0, n1, s0, s1);
        chk({tag, ".rdy"}, 32'(cfg_if.cfg_ready_out), 32'(1));
        chk({tag, ".err"}, 32'(cfg_if.cfg_err_out), 32'(0));
    endtask

    // Checks n blank samples, ending on the first post-blank sample.
    task automatic check_blank(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_ports(tag, OFF, OFF, OFF, OFF);
            chk({tag, ".rdy"}, 32'(cfg_if.cfg_ready_out), 32'(0));
            @(negedge clk);
        end
    endtask

    task automatic send_cfg(input logic c, input logic [1:0] p0,
                            input logic [1:0] p1);
        cfg_if.cfg_valid_in   = 1'b1;
        cfg_if.cfg_console_in = c;
        cfg_if.cfg_p0_in      = p0;
        cfg_if.cfg_p1_in      = p1;
        @(negedge clk);
        cfg_if.cfg_valid_in = 1'b0;
    endtask

    task automatic do_step();
        cfg_if.step_in = 1'b1;
        @(negedge clk);
        cfg_if.step_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        src0 = S0;
        src1 = S1;
        src2 = S2;
        cfg_if.cfg_valid_in   = 1'b0;
        cfg_if.cfg_console_in = 1'b0;
        cfg_if.cfg_p0_in      = '0;
        cfg_if.cfg_p1_in      = '0;
        cfg_if.step_in        = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_cur("rst", 1'b0, 2'd0, 2'd1);
        chk("rst.err", 32'(cfg_if.cfg_err_out), 32'(0));
        check_blank("rst_blank", BLANK);
        check_active("pwrup", S0, S1, OFF, OFF);

        send_cfg(1'b1, 2'd2, 2'd0);
        check_cur("load", 1'b1, 2'd2, 2'd0);
        check_blank("load_blank", BLANK);
        check_active("load_act", OFF, OFF, S2, S0);
        src2 = 12'h7FE;
        chk("lat.same", 32'(snes0), 32'(S2));
        @(negedge clk);
        chk("lat.next", 32'(snes0), 32'(12'h7FE));
        src2 = S2;
        @(negedge clk);

        send_cfg(1'b0, 2'd1, 2'd1);
        chk("ill1.err", 32'(cfg_if.cfg_err_out), 32'(1));
        chk("ill1.rdy", 32'(cfg_if.cfg_ready_out), 32'(1));
        check_cur("ill1", 1'b1, 2'd2, 2'd0);
        check_ports("ill1", OFF, OFF, S2, S0);
        @(negedge clk);
        chk("ill1.pulse", 32'(cfg_if.cfg_err_out), 32'(0));
        send_cfg(1'b0, 2'd3, 2'd0);
        chk("ill2.err", 32'(cfg_if.cfg_err_out), 32'(1));
        check_cur("ill2", 1'b1, 2'd2, 2'd0);
        @(negedge clk);
        chk("ill2.pulse", 32'(cfg_if.cfg_err_out), 32'(0));
        send_cfg(1'b1, 2'd2, 2'd0);
        check_active("same", OFF, OFF, S2, S0);
        check_cur("same", 1'b1, 2'd2, 2'd0);

        send_cfg(1'b0, 2'd0, 2'd2);
        check_blank("c002", BLANK);
        check_active("c002_act", S0, S2, OFF, OFF);
        do_step();
        check_cur("step1", 1'b0, 2'd1, 2'd0);
        check_blank("step1_blank", BLANK);
        check_active("step1_act", S1, S0, OFF, OFF);

        send_cfg(1'b1, 2'd2, 2'd1);
        check_blank("c121", BLANK);
        check_active("c121_act", OFF, OFF, S2, S1);
        do_step();
        check_cur("wrap", 1'b0, 2'd0, 2'd1);
        check_blank("wrap_blank", BLANK);
        check_active("wrap_act", S0, S1, OFF, OFF);

        cfg_if.step_in = 1'b1;
        send_cfg(1'b1, 2'd0, 2'd1);
        cfg_if.step_in = 1'b0;
        check_cur("prio", 1'b1, 2'd0, 2'd1);
        check_ports("ign.b1", OFF, OFF, OFF, OFF);
        cfg_if.step_in = 1'b1;
        @(negedge clk);
        cfg_if.step_in = 1'b0;
        check_ports("ign.b2", OFF, OFF, OFF, OFF);
        check_cur("ign.step", 1'b1, 2'd0, 2'd1);
        send_cfg(1'b0, 2'd2, 2'd1);
        check_ports("ign.b3", OFF, OFF, OFF, OFF);
        check_cur("ign.cfg", 1'b1, 2'd0, 2'd1);
        @(negedge clk);
        check_ports("ign.b4", OFF, OFF, OFF, OFF);
        chk("ign.b4.rdy", 32'(cfg_if.cfg_ready_out), 32'(0));
        @(negedge clk);
        check_active("ign_act", OFF, OFF, S0, S1);
        check_cur("ign_act", 1'b1, 2'd0, 2'd1);

        send_cfg(1'b0, 2'd2, 2'd0);
        check_ports("mid.b1", OFF, OFF, OFF, OFF);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_cur("mid_rst", 1'b0, 2'd0, 2'd1);
        check_blank("mid_blank", BLANK);
        check_active("mid_act", S0, S1, OFF, OFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/controller_router.md
Name: controller_router

Overview:
- Registered, runtime-configurable router from N_SRC active-low controller sources to the four console ports: NES player 0/1 and SNES player 0/1.
- Mapping is loaded over a valid/ready config interface or advanced by a step pulse.
- On every mapping change, all console ports are blanked to "released" for a fixed time, so a console never sees a stuck or mis-sourced button.
- Sits between the controller decoders (N64, remote, button board, …) and the console-side shift-register emulators.

Parameters:
- BTN_W, 12, button word width; bit = 0 means pressed.
- N_SRC, 3, number of source controllers; must be >= 2.
- BLANK_CYCLES, 16, number of cycles all ports read OFF after a mapping change or reset; must be >= 1.
- SEL_W, max(1, clog2(N_SRC)), width of a source index.

Ports:
- clk_in  in  1  system clock
- reset_in  in  1  synchronous reset, active-low
- src_in  in  N_SRC*BTN_W  source words; source k occupies bits [k*BTN_W +: BTN_W]
- cfg_valid_in  in  1  config request
- cfg_console_in  in  1  0 = NES, 1 = SNES
- cfg_p0_in  in  SEL_W  source index for player-0 port
- cfg_p1_in  in  SEL_W  source index for player-1 port
- cfg_ready_out  out  1  config/step may be accepted this cycle
- cfg_err_out  out  1  one-cycle pulse: illegal config rejected
- step_in  in  1  single-cycle pulse: advance to next legal mapping
- cur_console_out  out  1  committed console
- cur_p0_out  out  SEL_W  committed player-0 source
- cur_p1_out  out  SEL_W  committed player-1 source
- NES0, NES1, SNES0, SNES1  out  BTN_W each  console port words

Behaviour:
- OFF = all ones (BTN_W bits).
- States: BLANK, ACTIVE. A down-counter of width clog2(BLANK_CYCLES+1) runs in BLANK.
- Reset (reset_in = 0 at a clock edge):
  - State = BLANK, counter = BLANK_CYCLES.
  - Committed config = (NES, p0 = 0, p1 = 1).
  - All port outputs = OFF; cfg_ready_out = 0; cfg_err_out = 0.
  - Reset mid-BLANK or mid-operation behaves identically: the blank restarts in full.
- BLANK state:
  - All four ports = OFF; cfg_ready_out = 0.
  - cfg_valid_in and step_in are ignored (not queued).
  - The counter decrements each cycle. When it reaches 0, the state becomes ACTIVE.
  - Net effect: ports read OFF for exactly BLANK_CYCLES cycles after the acceptance/reset edge.
- ACTIVE state:
  - cfg_ready_out = 1.
  - Ports are registered with 1-cycle latency: a port at cycle t+1 equals its mapped src word at cycle t.
  - Selected console: port 0 = src[p0], port 1 = src[p1]. Both ports of the other console = OFF.
- Config legality: console is any value; p0 < N_SRC; p1 < N_SRC; p0 != p1.
- cfg_valid_in while ACTIVE:
  - Legal and different from committed: commit the new config (cur_* update at this edge), enter BLANK.
  - Legal and identical to committed: no-op; no blank, no error.
  - Illegal: cfg_err_out = 1 for the next cycle only; config and state unchanged.
- step_in while ACTIVE (and cfg_valid_in low): commit the next legal mapping, enter BLANK.
  - Order is lexicographic on (console, p0, p1): console most significant, p1 least, skipping p0 == p1.
  - After (SNES, N_SRC-1, N_SRC-2), wrap to (NES, 0, 1).
- cfg_valid_in and step_in in the same ACTIVE cycle: the config request wins and the step is dropped.
- The cur_* outputs always show the committed config, including during BLANK.
- All out-of-range index arithmetic is explicit. There is no implicit wrap on SEL_W when N_SRC is not a power of 2.

Test Plan:
(BTN_W = 12, N_SRC = 3, BLANK_CYCLES = 4; src0 = 12'hFFE, src1 = 12'hFFD, src2 = 12'h7FF)
- Reset and power-up blank:
  - Stimulus: reset_in = 0 for 3 cycles, then release.
  - Response: all ports = 12'hFFF and cfg_ready_out = 0 for 4 cycles. Then NES0 = FFE, NES1 = FFD, SNES0 = SNES1 = FFF, cfg_ready_out = 1.
- Config load:
  - Stimulus: cfg (SNES, p0 = 2, p1 = 0) accepted.
  - Response: cur_* = (1, 2, 0) at the next cycle; all ports FFF for 4 cycles. Then SNES0 = 7FF, SNES1 = FFE, NES0 = NES1 = FFF. A src2 change propagates to SNES0 one cycle later.
- Illegal and identical config:
  - Stimulus: cfg (NES, 1, 1), then cfg (NES, 3, 0), then cfg equal to the committed config.
  - Response: two single-cycle cfg_err_out pulses; no blank for any of the three; ports and cur_* unchanged.
- Step order and wrap:
  - Stimulus/response: from (NES, 0, 2), step → (NES, 1, 0). From (SNES, 2, 1), step → (NES, 0, 1). Each step is followed by a 4-cycle blank.
- Priority and ignore:
  - Stimulus: cfg_valid_in and step_in asserted together.
  - Response: only the cfg is applied.
  - Stimulus: step_in or cfg_valid_in asserted during BLANK.
  - Response: ignored; cur_* unchanged; the blank is not extended.
- Reset mid-blank:
  - Stimulus: assert reset at blank cycle 2 after a cfg change.
  - Response: cur_* = (0, 0, 1); a full 4-cycle blank restarts after release.
